// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enabled single-port memory: read-during-write
// mode codes, clear-sequencer state encoding and the byte merge helper.
package mem_pkg;

    localparam int RDW_NO_CHANGE   = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_WRITE_FIRST = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Select the new byte when its enable is set, otherwise keep the old one.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/mem_clr_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, and
// raises busy for the whole walk so the array port is reserved for it.
module mem_clr_seq
    import mem_pkg::*;
#(
    parameter int ADDR         = 16,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            busy,
    output logic [ADDR-1:0] clr_addr,
    output logic            clr_we
);

    // One extra counter bit keeps the last-address compare exact.
    localparam logic [ADDR:0] LAST_ADDR = {1'b0, {ADDR{1'b1}}};

    clr_state_e      state_q, state_d;
    logic [ADDR:0]   cnt_q, cnt_d;

    // Next-state and counter advance; the last word is written in the cycle that returns to IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = cnt_q[ADDR-1:0];
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
            end
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset restarts the walk from address zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sp_mem_be.sv
// Single-port synchronous RAM with per-byte write enables, read strobe with a
// one-cycle valid pulse, read latency 1 or 2, selectable read-during-write
// behaviour and an optional zero-fill of the whole array after reset.
module sp_mem_be
    import mem_pkg::*;
#(
    parameter int WORD         = 32,
    parameter int ADDR         = 16,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR-1:0]   A,
    input  logic              R,
    input  logic              W,
    input  logic [WORD/8-1:0] BE,
    input  logic [WORD-1:0]   D,
    output logic [WORD-1:0]   Q,
    output logic              QV,
    output logic              BUSY
);

    localparam int NB    = WORD / 8;
    localparam int DEPTH = 1 << ADDR;

    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
        $error("sp_mem_be: RD_LAT must be 1 or 2");
    end
    if ((WORD % 8) != 0) begin : g_bad_word
        $error("sp_mem_be: WORD must be a multiple of 8");
    end
    if ((RDW_MODE < 0) || (RDW_MODE > 2)) begin : g_bad_rdw
        $error("sp_mem_be: RDW_MODE must be 0, 1 or 2");
    end

    // BE-masked new data laid over the old word.
    function automatic logic [WORD-1:0] merge_word(input logic [WORD-1:0] old_w,
                                                   input logic [WORD-1:0] new_w,
                                                   input logic [NB-1:0]   be);
        logic [WORD-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            res[8*i +: 8] = merge_byte(old_w[8*i +: 8], new_w[8*i +: 8], be[i]);
        end
        return res;
    endfunction

    logic [WORD-1:0] mem [DEPTH];

    logic            busy;
    logic [ADDR-1:0] clr_addr;
    logic            clr_we;

    mem_clr_seq #(
        .ADDR         (ADDR),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    logic            acc;
    logic            wr_en;
    logic [ADDR-1:0] wr_addr;
    logic [NB-1:0]   wr_be;
    logic [WORD-1:0] wr_data;
    logic [WORD-1:0] old_word;
    logic            rd_vld_p0;
    logic [WORD-1:0] rd_data_p0;

    // Port arbitration: the clear sequencer owns the write port while busy,
    // otherwise an accepted request drives it. The read word is formed here.
    always_comb begin
        acc     = (R | W) & ~busy & ~rst;
        wr_en   = (clr_we & ~rst) | (acc & W);
        wr_addr = A;
        wr_be   = BE;
        wr_data = D;
        if (busy) begin
            wr_addr = clr_addr;
            wr_be   = '1;
            wr_data = '0;
        end
        old_word   = mem[A];
        rd_vld_p0  = acc & R & (~W | (RDW_MODE != RDW_NO_CHANGE));
        rd_data_p0 = (W && (RDW_MODE == RDW_WRITE_FIRST)) ? merge_word(old_word, D, BE)
                                                          : old_word;
    end

    // Array write, one byte lane at a time so untouched bytes keep their value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    logic            vld_p1_q, vld_p1_d;
    logic [WORD-1:0] data_p1_q, data_p1_d;
    logic            qv_q, qv_d;
    logic [WORD-1:0] q_q, q_d;
    logic            out_vld;
    logic [WORD-1:0] out_data;

    // Latency pipeline: with RD_LAT=2 the read passes through one stage register
    // before reaching Q; Q only changes on a valid read.
    always_comb begin
        vld_p1_d  = rd_vld_p0;
        data_p1_d = rd_vld_p0 ? rd_data_p0 : data_p1_q;
        out_vld   = (RD_LAT == 2) ? vld_p1_q  : rd_vld_p0;
        out_data  = (RD_LAT == 2) ? data_p1_q : rd_data_p0;
        qv_d      = out_vld;
        q_d       = out_vld ? out_data : q_q;
    end

    // ---- stage p1 / output boundary: control and Q cleared by reset ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            qv_q     <= 1'b0;
            q_q      <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            qv_q     <= qv_d;
            q_q      <= q_d;
        end
    end

    // Stage data register carries no reset; its valid bit qualifies it.
    always_ff @(posedge clk) begin
        data_p1_q <= data_p1_d;
    end

    assign Q    = q_q;
    assign QV   = qv_q;
    assign BUSY = busy;

endmodule

// File: tb/tb_sp_mem_be.sv
// Bench for sp_mem_be: four instances (latency/read-during-write variants) on
// shared stimulus, checked every cycle against a behavioural model, plus
// directed scenarios with literal expectations.
module tb_sp_mem_be;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    logic        r;
    logic        w;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] q  [4];
    logic        qv [4];
    logic        bz [4];

    int total = 0;
    int bad   = 0;

    sp_mem_be #(.WORD(32), .ADDR(4), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst), .A(addr), .R(r), .W(w), .BE(be), .D(din),
        .Q(q[0]), .QV(qv[0]), .BUSY(bz[0]));
    sp_mem_be #(.WORD(32), .ADDR(4), .RD_LAT(1), .RDW_MODE(1), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst(rst), .A(addr), .R(r), .W(w), .BE(be), .D(din),
        .Q(q[1]), .QV(qv[1]), .BUSY(bz[1]));
    sp_mem_be #(.WORD(32), .ADDR(4), .RD_LAT(2), .RDW_MODE(2), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst), .A(addr), .R(r), .W(w), .BE(be), .D(din),
        .Q(q[2]), .QV(qv[2]), .BUSY(bz[2]));
    sp_mem_be #(.WORD(32), .ADDR(4), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RST(1)) u3 (
        .clk(clk), .rst(rst), .A(addr), .R(r), .W(w), .BE(be), .D(din),
        .Q(q[3]), .QV(qv[3]), .BUSY(bz[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          lat_k  [4] = '{1, 1, 2, 2};
    int          mode_k [4] = '{0, 1, 2, 0};
    logic [31:0] mm [16];
    int          left = 0;
    bit          started = 0;
    logic [31:0] mq  [4];
    bit          mqv [4];
    bit          pv  [4];
    logic [31:0] pd  [4];

    function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] m);
        logic [31:0] mask;
        mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    always @(posedge clk) begin
        bit          accd;
        bit          evv;
        logic [31:0] evd;
        logic [31:0] old_w;
        logic [31:0] new_w;
        if (rst) begin
            started = 1;
            left    = 16;
            for (int k = 0; k < 4; k++) begin
                mq[k] = 32'h0; mqv[k] = 0; pv[k] = 0; pd[k] = 32'h0;
            end
        end else begin
            accd  = (r || w) && (left == 0);
            old_w = mm[addr];
            new_w = be_merge(old_w, din, be);
            for (int k = 0; k < 4; k++) begin
                evv = 0;
                evd = 32'h0;
                if (accd && r) begin
                    if (!w) begin
                        evv = 1; evd = old_w;
                    end else if (mode_k[k] == 1) begin
                        evv = 1; evd = old_w;
                    end else if (mode_k[k] == 2) begin
                        evv = 1; evd = new_w;
                    end
                end
                if (lat_k[k] == 1) begin
                    mqv[k] = evv;
                    if (evv) mq[k] = evd;
                end else begin
                    mqv[k] = pv[k];
                    if (pv[k]) mq[k] = pd[k];
                    pv[k] = evv;
                    pd[k] = evd;
                end
            end
            if (accd && w) mm[addr] = new_w;
            if (left > 0) begin
                mm[16 - left] = 32'h0;
                left = left - 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (started) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (qv[k] !== mqv[k]) begin
                    bad++;
                    if (bad < 40) $display("FAIL qv[%0d] t=%0t: got %b want %b", k, $time, qv[k], mqv[k]);
                end
                total++;
                if (q[k] !== mq[k]) begin
                    bad++;
                    if (bad < 40) $display("FAIL q[%0d] t=%0t: got %h want %h", k, $time, q[k], mq[k]);
                end
                total++;
                if (bz[k] !== (left > 0)) begin
                    bad++;
                    if (bad < 40) $display("FAIL busy[%0d] t=%0t: got %b want %b", k, $time, bz[k], left > 0);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %h want %h", nm, $time, got, exp);
        end
    endtask

    task automatic op(input logic rr, input logic ww, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        r = rr; w = ww; addr = a; din = d; be = m;
    endtask

    task automatic idle();
        @(negedge clk);
        r = 1'b0; w = 1'b0;
    endtask

    // Read one word and check it on the latency-1 and latency-2 instances.
    task automatic read_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
        op(1'b1, 1'b0, a, 32'h0, 4'h0);
        idle();
        chk({nm, "_qv1"}, {31'h0, qv[0]}, 32'h1);
        chk({nm, "_q1"}, q[0], exp);
        chk({nm, "_model"}, mq[0], exp);
        @(negedge clk);
        chk({nm, "_qv2"}, {31'h0, qv[2]}, 32'h1);
        chk({nm, "_q2"}, q[2], exp);
    endtask

    // Pulse reset with a request held, then count cycles with BUSY high.
    // Any write request is dropped as soon as BUSY falls.
    task automatic reset_count(input logic hr, input logic hw, input logic [3:0] a,
                               input logic [31:0] d, output int n);
        @(negedge clk);
        rst = 1'b1; r = hr; w = hw; addr = a; din = d; be = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (bz[0] && n < 100) begin
            n++;
            chk("busy_no_qv", {31'h0, qv[0] | qv[1] | qv[2] | qv[3]}, 32'h0);
            @(negedge clk);
        end
        w = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] v [3];
        rst = 1'b1; r = 1'b0; w = 1'b0; addr = 4'h0; din = 32'h0; be = 4'h0;
        for (int i = 0; i < 16; i++) mm[i] = 32'h0;

        // Power-up reset, reset state, BUSY duration.
        reset_count(1'b0, 1'b0, 4'h0, 32'h0, n);
        chk("busy_len_init", n, 16);
        chk("rst_q", q[0], 32'h0);
        chk("rst_qv", {31'h0, qv[0]}, 32'h0);

        // Pre-load, then clear with a read held throughout.
        op(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF);
        read_chk(4'd5, 32'hDEADBEEF, "preload");
        reset_count(1'b1, 1'b0, 4'd5, 32'h0, n);
        chk("busy_len_clear", n, 16);
        @(negedge clk);
        r = 1'b0;
        chk("clr_first_qv", {31'h0, qv[0]}, 32'h1);
        chk("clr_first_q", q[0], 32'h0);
        @(negedge clk);
        chk("clr_first_qv2", {31'h0, qv[2]}, 32'h1);
        chk("clr_first_q2", q[2], 32'h0);

        // Byte enables.
        op(1'b0, 1'b1, 4'd3, 32'h11223344, 4'b1111);
        op(1'b0, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
        read_chk(4'd3, 32'h11BB33DD, "byte_en");
        op(1'b0, 1'b1, 4'd3, 32'h99999999, 4'b0000);
        read_chk(4'd3, 32'h11BB33DD, "be_zero");

        // Back-to-back reads through the two-stage pipeline.
        v[0] = 32'hA1A1A1A1; v[1] = 32'hB2B2B2B2; v[2] = 32'hC3C3C3C3;
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 4'(i + 1), v[i], 4'hF);
        op(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
        op(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
        chk("lat2_early_qv", {31'h0, qv[2]}, 32'h0);
        op(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        chk("lat2_qv_a", {31'h0, qv[2]}, 32'h1);
        chk("lat2_q_a", q[2], v[0]);
        idle();
        chk("lat2_qv_b", {31'h0, qv[2]}, 32'h1);
        chk("lat2_q_b", q[2], v[1]);
        @(negedge clk);
        chk("lat2_qv_c", {31'h0, qv[2]}, 32'h1);
        chk("lat2_q_c", q[2], v[2]);
        @(negedge clk);
        chk("lat2_qv_end", {31'h0, qv[2]}, 32'h0);
        chk("lat2_q_hold", q[2], v[2]);

        // Read-during-write modes.
        op(1'b0, 1'b1, 4'd7, 32'h0000FFFF, 4'hF);
        op(1'b1, 1'b1, 4'd7, 32'h12345678, 4'hF);
        idle();
        chk("rdw0_qv", {31'h0, qv[0]}, 32'h0);
        chk("rdw0_q", q[0], v[2]);
        chk("rdw1_qv", {31'h0, qv[1]}, 32'h1);
        chk("rdw1_q", q[1], 32'h0000FFFF);
        @(negedge clk);
        chk("rdw2_qv", {31'h0, qv[2]}, 32'h1);
        chk("rdw2_q", q[2], 32'h12345678);
        chk("rdw0_lat2_qv", {31'h0, qv[3]}, 32'h0);
        chk("rdw0_lat2_q", q[3], v[2]);
        read_chk(4'd7, 32'h12345678, "rdw_after");
        chk("rdw_after_m1", q[1], 32'h12345678);
        chk("rdw_after_m0l2", q[3], 32'h12345678);

        // Reset mid-clear, with a write attempted while busy.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        reset_count(1'b0, 1'b1, 4'd2, 32'hFFFFFFFF, n);
        chk("busy_len_restart", n, 16);
        for (int i = 0; i < 16; i++) read_chk(4'(i), 32'h0, "cleared");

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 599) == 0);
            r    = ($urandom_range(0, 1) == 1);
            w    = ($urandom_range(0, 2) == 0);
            addr = 4'($urandom_range(0, 15));
            be   = 4'($urandom_range(0, 15));
            din  = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; r = 1'b0; w = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
